// File: rtl/conv2_feeder_pkg.sv
// Shared constants, FSM encoding and address helpers for the conv2 stream feeder.
package conv2_feeder_pkg;

    localparam int unsigned KERNEL   = 3;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned WEIGHT_W = 8;
    localparam int unsigned N_OUT    = 16;
    localparam int unsigned N_CH     = 30;
    localparam int unsigned N_POS    = 42;
    localparam int unsigned IN_LEN   = N_POS + KERNEL - 1;
    localparam int unsigned WROW_W   = WEIGHT_W * N_OUT;

    localparam int unsigned FM_AW    = $clog2(N_CH * IN_LEN);
    localparam int unsigned WR_AW    = $clog2(N_CH * KERNEL);
    localparam int unsigned CH_W     = $clog2(N_CH);
    localparam int unsigned POS_W    = $clog2(N_POS);
    localparam int unsigned K_W      = $clog2(KERNEL);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        DRAIN    = 3'd2,
        WAIT_END = 3'd3,
        DONE     = 3'd4
    } state_t;

    // One tap as delivered to the layer: sample plus its full weight row.
    typedef struct packed {
        logic [DATA_W-1:0] sample;
        logic [WROW_W-1:0] weights;
    } tap_t;

    function automatic logic [FM_AW-1:0] fm_addr_f(
        input logic [CH_W-1:0]  ch,
        input logic [POS_W-1:0] pos,
        input logic [K_W-1:0]   k
    );
        return FM_AW'(ch) * FM_AW'(IN_LEN) + FM_AW'(pos) + FM_AW'(k);
    endfunction

    function automatic logic [WR_AW-1:0] wr_addr_f(
        input logic [CH_W-1:0] ch,
        input logic [K_W-1:0]  k
    );
        return WR_AW'(ch) * WR_AW'(KERNEL) + WR_AW'(k);
    endfunction

endpackage

// File: rtl/conv2_feeder_addr_gen.sv
// Channel/position/tap counters with registered feature and weight RAM addresses.
// Addresses and wrap flags are loaded from the next counter values so they track the counters.
module conv2_feeder_addr_gen
    import conv2_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic             i_k_inc,
    output logic [FM_AW-1:0] o_fm_addr,
    output logic [WR_AW-1:0] o_wr_addr,
    output logic             o_last_k,
    output logic             o_last_pos,
    output logic             o_last_ch
);

    logic [CH_W-1:0]  r_ch;
    logic [POS_W-1:0] r_pos;
    logic [K_W-1:0]   r_k;
    logic [CH_W-1:0]  w_ch_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic [K_W-1:0]   w_k_nxt;
    logic [FM_AW-1:0] r_fm_addr;
    logic [WR_AW-1:0] r_wr_addr;
    logic             r_last_k;
    logic             r_last_pos;
    logic             r_last_ch;

    // Counter stepping: clear beats window advance beats tap increment.
    always_comb begin
        w_ch_nxt  = r_ch;
        w_pos_nxt = r_pos;
        w_k_nxt   = r_k;
        if (i_clr) begin
            w_ch_nxt  = '0;
            w_pos_nxt = '0;
            w_k_nxt   = '0;
        end else if (i_adv) begin
            w_k_nxt = '0;
            if (r_pos == POS_W'(N_POS - 1)) begin
                w_pos_nxt = '0;
                w_ch_nxt  = (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + CH_W'(1);
            end else begin
                w_pos_nxt = r_pos + POS_W'(1);
            end
        end else if (i_k_inc) begin
            w_k_nxt = (r_k == K_W'(KERNEL - 1)) ? '0 : r_k + K_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch       <= '0;
            r_pos      <= '0;
            r_k        <= '0;
            r_fm_addr  <= '0;
            r_wr_addr  <= '0;
            r_last_k   <= 1'b0;
            r_last_pos <= 1'b0;
            r_last_ch  <= 1'b0;
        end else begin
            r_ch       <= w_ch_nxt;
            r_pos      <= w_pos_nxt;
            r_k        <= w_k_nxt;
            r_fm_addr  <= fm_addr_f(w_ch_nxt, w_pos_nxt, w_k_nxt);
            r_wr_addr  <= wr_addr_f(w_ch_nxt, w_k_nxt);
            r_last_k   <= (w_k_nxt == K_W'(KERNEL - 1));
            r_last_pos <= (w_pos_nxt == POS_W'(N_POS - 1));
            r_last_ch  <= (w_ch_nxt == CH_W'(N_CH - 1));
        end
    end

    assign o_fm_addr  = r_fm_addr;
    assign o_wr_addr  = r_wr_addr;
    assign o_last_k   = r_last_k;
    assign o_last_pos = r_last_pos;
    assign o_last_ch  = r_last_ch;

endmodule

// File: rtl/conv2_feeder.sv
// Conv2 stream source: issues KERNEL-tap windows from the feature and weight RAMs,
// waits for the layer's end pulse per convolution, and walks all channels and positions.
module conv2_feeder
    import conv2_feeder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [FM_AW-1:0]         fm_addr,
    output logic                     fm_rd,
    input  logic [DATA_W-1:0]        fm_rdata,
    output logic [WR_AW-1:0]         wr_addr,
    output logic                     wr_rd,
    input  logic [WROW_W-1:0]        wr_rdata,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     valid_o,
    output logic                     w_en_o,
    output logic [WROW_W-1:0]        w_o,
    input  logic                     conv_end_i,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_drain_cnt;
    logic   w_drain_nxt;
    logic   r_err;
    logic   w_err_nxt;
    logic   w_clr;
    logic   w_adv;
    logic   w_k_inc;
    logic   w_last_k;
    logic   w_last_pos;
    logic   w_last_ch;
    logic   r_rd;
    logic   r_busy;
    logic   r_done;
    logic   r_pipe_vld;
    logic   r_valid;
    tap_t   r_tap;

    conv2_feeder_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_adv      (w_adv),
        .i_k_inc    (w_k_inc),
        .o_fm_addr  (fm_addr),
        .o_wr_addr  (wr_addr),
        .o_last_k   (w_last_k),
        .o_last_pos (w_last_pos),
        .o_last_ch  (w_last_ch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Sequencing; abort overrides everything, including a simultaneous start.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_err_nxt   = r_err;
        w_clr       = 1'b0;
        w_adv       = 1'b0;
        w_k_inc     = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
            w_drain_nxt = 1'b0;
            w_clr       = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = ISSUE;
                        w_clr       = 1'b1;
                        w_err_nxt   = 1'b0;
                    end
                end
                ISSUE: begin
                    if (conv_end_i) w_err_nxt = 1'b1;
                    if (w_last_k) begin
                        w_state_nxt = DRAIN;
                        w_drain_nxt = 1'b0;
                    end else begin
                        w_k_inc = 1'b1;
                    end
                end
                DRAIN: begin
                    if (conv_end_i) w_err_nxt = 1'b1;
                    w_drain_nxt = ~r_drain_cnt;
                    if (r_drain_cnt) w_state_nxt = WAIT_END;
                end
                WAIT_END: begin
                    if (conv_end_i) begin
                        if (w_last_pos && w_last_ch) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = ISSUE;
                            w_adv       = 1'b1;
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Registered status plus the two-stage read pipeline (RAM latency, then output capture).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pipe_vld <= 1'b0;
            r_valid    <= 1'b0;
            r_tap      <= '0;
        end else begin
            r_rd   <= (w_state_nxt == ISSUE);
            r_busy <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN) ||
                      (w_state_nxt == WAIT_END);
            r_done <= (w_state_nxt == DONE);
            if (abort) begin
                r_pipe_vld <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_pipe_vld <= r_rd;
                r_valid    <= r_pipe_vld;
                if (r_pipe_vld) begin
                    r_tap.sample  <= fm_rdata;
                    r_tap.weights <= wr_rdata;
                end
            end
        end
    end

    assign fm_rd   = r_rd;
    assign wr_rd   = r_rd;
    assign data_o  = r_tap.sample;
    assign w_o     = r_tap.weights;
    assign valid_o = r_valid;
    assign w_en_o  = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_conv2_feeder.sv
// Randomized self-checking bench for conv2_feeder against a window-level model
// of the feature/weight streams, with RAM models and a conv_end responder.
module tb_conv2_feeder;
    import conv2_feeder_pkg::*;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic              abort      = 1'b0;
    logic              conv_end_i = 1'b0;
    logic [FM_AW-1:0]  fm_addr;
    logic              fm_rd;
    logic [DATA_W-1:0] fm_rdata   = '0;
    logic [WR_AW-1:0]  wr_addr;
    logic              wr_rd;
    logic [WROW_W-1:0] wr_rdata   = '0;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              w_en_o;
    logic [WROW_W-1:0] w_o;
    logic              busy;
    logic              done;
    logic              err;

    int n_chk = 0;
    int n_fail = 0;
    int m_ch = 0, m_pos = 0, m_k = 0;
    int i_ch = 0, i_pos = 0, i_k = 0;
    int end_cnt = 0, n_valid = 0, n_win = 0, n_end = 0, n_done = 0;
    int last_fm = -1, last_wr = -1, wrap_fm = -1, wrap_wr = -1;
    int cyc;
    logic [DATA_W-1:0] exp_last_d = '0;
    logic [WROW_W-1:0] exp_last_w = '0;
    bit auto_end = 1'b1;
    bit man_req  = 1'b0;
    bit mdl_clr  = 1'b0;

    conv2_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .fm_addr    (fm_addr),
        .fm_rd      (fm_rd),
        .fm_rdata   (fm_rdata),
        .wr_addr    (wr_addr),
        .wr_rd      (wr_rd),
        .wr_rdata   (wr_rdata),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .w_en_o     (w_en_o),
        .w_o        (w_o),
        .conv_end_i (conv_end_i),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [WROW_W-1:0] row_of(input int r);
        logic [WROW_W-1:0] row;
        for (int j = 0; j < int'(N_OUT); j++) row[j*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(r);
        return row;
    endfunction

    // Synchronous RAMs: fm[i] = i mod 128, weight row r = r replicated in every lane.
    always @(posedge clk) begin
        if (fm_rd) fm_rdata <= DATA_W'(int'(fm_addr) % 128);
        if (wr_rd) wr_rdata <= row_of(int'(wr_addr));
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Window-level model, address model and conv_end responder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n || mdl_clr) begin
            m_ch = 0; m_pos = 0; m_k = 0;
            i_ch = 0; i_pos = 0; i_k = 0;
            end_cnt = 0;
            conv_end_i = 1'b0;
            if (!rst_n) begin
                exp_last_d = '0;
                exp_last_w = '0;
            end
        end else begin
            conv_end_i = 1'b0;
            if (man_req) begin
                conv_end_i = 1'b1;
            end else if (end_cnt > 0) begin
                end_cnt--;
                if (end_cnt == 0) conv_end_i = 1'b1;
            end
            if (conv_end_i) n_end++;

            check("w_en_eq_valid", w_en_o, valid_o);
            if (fm_rd) begin
                check("fm_addr", fm_addr, i_ch * IN_LEN + i_pos + i_k);
                check("wr_addr", wr_addr, i_ch * KERNEL + i_k);
                check("wr_rd", wr_rd, 1);
                last_fm = int'(fm_addr);
                last_wr = int'(wr_addr);
                if (i_ch == 1 && i_pos == 0 && i_k == 0) begin
                    wrap_fm = int'(fm_addr);
                    wrap_wr = int'(wr_addr);
                end
                i_k++;
                if (i_k == int'(KERNEL)) begin
                    i_k = 0;
                    i_pos++;
                    if (i_pos == int'(N_POS)) begin
                        i_pos = 0;
                        i_ch++;
                        if (i_ch == int'(N_CH)) i_ch = 0;
                    end
                end
            end

            if (m_k != 0) check("valid_gap", valid_o, 1);
            if (valid_o) begin
                exp_last_d = DATA_W'((m_ch * IN_LEN + m_pos + m_k) % 128);
                exp_last_w = row_of(m_ch * KERNEL + m_k);
                check("data_o", data_o, exp_last_d);
                check("w_o", w_o, exp_last_w);
                n_valid++;
                m_k++;
                if (m_k == int'(KERNEL)) begin
                    m_k = 0;
                    n_win++;
                    if (auto_end) end_cnt = (n_win == 1) ? 3 : int'($urandom_range(8, 1));
                    m_pos++;
                    if (m_pos == int'(N_POS)) begin
                        m_pos = 0;
                        m_ch++;
                        if (m_ch == int'(N_CH)) m_ch = 0;
                    end
                end
            end else begin
                check("data_hold", data_o, exp_last_d);
                check("w_hold", w_o, exp_last_w);
            end

            if (done) begin
                n_done++;
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        step(3);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_fm_rd", fm_rd, 0);
        check("rst_fm_addr", fm_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_data", data_o, 0);
        rst_n = 1'b1;
        step(2);

        // Pass 1: complete walk with randomized conv_end latency.
        pulse_start();
        check("busy_after_start", busy, 1);
        check("fm_rd_c1", fm_rd, 1);
        check("valid_c1", valid_o, 0);
        step(1);
        check("valid_c2", valid_o, 0);
        step(1);
        check("valid_c3", valid_o, 1);
        check("first_tap0", data_o, 0);
        check("first_w0", w_o, row_of(0));
        step(1);
        check("first_tap1", data_o, 1);
        check("first_w1", w_o, row_of(1));
        step(1);
        check("first_tap2", data_o, 2);
        check("first_w2", w_o, row_of(2));
        cyc = 0;
        while (n_done == 0 && cyc < 40000) begin
            step(1);
            cyc++;
        end
        step(3);
        check("pass1_done_cnt", n_done, 1);
        check("pass1_valid_cnt", n_valid, 3780);
        check("pass1_win_cnt", n_win, 1260);
        check("pass1_end_cnt", n_end, 1260);
        check("pass1_busy_after", busy, 0);
        check("pass1_err", err, 0);
        check("last_fm_addr", last_fm, 29 * 44 + 41 + 2);
        check("last_wr_addr", last_wr, 89);
        check("wrap_fm_addr", wrap_fm, 44);
        check("wrap_wr_addr", wrap_wr, 3);

        // conv_end while idle is ignored without error.
        man_req = 1'b1;
        step(1);
        man_req = 1'b0;
        step(2);
        check("idle_end_err", err, 0);
        check("idle_end_busy", busy, 0);

        // Pass 2: long wait, start while busy, conv_end in DRAIN, then abort.
        auto_end = 1'b0;
        pulse_start();
        step(6);
        for (int i = 0; i < 50; i++) begin
            check("wait_valid", valid_o, 0);
            check("wait_fm_rd", fm_rd, 0);
            check("wait_fm_addr", fm_addr, 2);
            check("wait_wr_addr", wr_addr, 2);
            start = (i == 10);
            step(1);
        end
        start = 1'b0;
        man_req = 1'b1;
        step(1);
        man_req = 1'b0;
        check("issue_after_end", fm_rd, 1);
        check("issue_fm_addr", fm_addr, 1);
        check("issue_wr_addr", wr_addr, 0);
        step(3);
        check("drain_fm_rd", fm_rd, 0);
        man_req = 1'b1;
        step(1);
        man_req = 1'b0;
        check("err_drain_end", err, 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("drain_end_no_issue", fm_rd, 0);
            check("drain_end_no_valid", valid_o, 0);
        end
        auto_end = 1'b1;
        man_req = 1'b1;
        step(1);
        man_req = 1'b0;
        check("err_sticky", err, 1);
        cyc = 0;
        while (!(valid_o && m_ch == 0 && m_pos == 5 && m_k == 1) && cyc < 2000) begin
            step(1);
            cyc++;
        end
        check("abort_point_reached", cyc < 2000, 1);
        abort = 1'b1;
        start = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        mdl_clr = 1'b1;
        check("abort_valid", valid_o, 0);
        check("abort_busy", busy, 0);
        check("abort_fm_rd", fm_rd, 0);
        check("abort_fm_addr", fm_addr, 0);
        check("abort_err_kept", err, 1);
        step(1);
        mdl_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("post_abort_valid", valid_o, 0);
            check("post_abort_busy", busy, 0);
            check("post_abort_done", done, 0);
            step(1);
        end

        // Pass 3: restart from the origin, then reset mid-pass.
        pulse_start();
        check("restart_err_clr", err, 0);
        check("restart_busy", busy, 1);
        check("restart_fm_rd", fm_rd, 1);
        check("restart_fm_addr", fm_addr, 0);
        check("restart_wr_addr", wr_addr, 0);
        step(2);
        check("restart_valid", valid_o, 1);
        check("restart_tap0", data_o, 0);
        cyc = 0;
        while (m_pos < 3 && cyc < 500) begin
            step(1);
            cyc++;
        end
        check("pass3_progress", m_pos, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fm_rd", fm_rd, 0);
        check("midrst_fm_addr", fm_addr, 0);
        check("midrst_data", data_o, 0);
        check("midrst_w", w_o, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("after_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
